// File: rtl/sbus_warbiter_if.sv
// S-bus write-channel bundle: requester-side request/ack signals plus the external bus port.
// slave = arbiter side, master = requesters and bus model.
interface sbus_warbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 48,
    parameter int DW   = 176
) ();
    logic [NREQ-1:0]    req_wrequest;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_waddr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_wack;
    logic               Swack;
    logic               Swrequest;
    logic [AW-1:0]      Swaddr;
    logic [DW-1:0]      Swdata;
    logic [2:0]         grant_id;
    logic               busy;
    logic               err_spurious_ack;

    modport slave (
        input  req_wrequest, req_lock, req_waddr, req_wdata, Swack,
        output req_wack, Swrequest, Swaddr, Swdata, grant_id, busy, err_spurious_ack
    );

    modport master (
        output req_wrequest, req_lock, req_waddr, req_wdata, Swack,
        input  req_wack, Swrequest, Swaddr, Swdata, grant_id, busy, err_spurious_ack
    );
endinterface

// File: rtl/sbus_warbiter.sv
// Round-robin owner arbiter for the single S-bus write channel, with optional burst lock.
// Define SBUS_WARB_TIMEOUT_EN to force-release a HOLD that sees no re-request for HOLD_TIMEOUT cycles.
module sbus_warbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 48,
    parameter int DW   = 176
`ifdef SBUS_WARB_TIMEOUT_EN
    ,
    parameter int HOLD_TIMEOUT = 16
`endif
) (
    input  logic             Sclk,
    input  logic             Sreset,
    sbus_warbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_owner;
    logic [2:0] r_ptr;
    logic       r_err;

    logic [7:0] w_req;
    logic [7:0] w_lock;
    logic [2:0] w_pick_idx;
    logic       w_pick_valid;
    logic [2:0] w_next_ptr;
    logic       w_swrequest;

`ifdef SBUS_WARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
    logic [CNT_W-1:0] r_hold_cnt;
`endif

    // Zero-extend to the full 3-bit index space so r_owner can index without width games.
    always_comb begin
        w_req              = '0;
        w_req[NREQ-1:0]    = bus.req_wrequest;
        w_lock             = '0;
        w_lock[NREQ-1:0]   = bus.req_lock;
    end

    // Descending scan: the last hit is the first requester in ptr, ptr+1, ... order.
    always_comb begin
        int j;
        w_pick_idx   = '0;
        w_pick_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (w_req[j]) begin
                w_pick_idx   = 3'(j);
                w_pick_valid = 1'b1;
            end
        end
    end

    assign w_next_ptr  = (r_owner == 3'(NREQ - 1)) ? 3'd0 : r_owner + 3'd1;
    assign w_swrequest = (r_state == S_GRANT) && w_req[r_owner];

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        bus.Swaddr   = '0;
        bus.Swdata   = '0;
        bus.req_wack = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_swrequest && r_owner == 3'(i)) begin
                bus.Swaddr      = bus.req_waddr[i*AW +: AW];
                bus.Swdata      = bus.req_wdata[i*DW +: DW];
                bus.req_wack[i] = bus.Swack;
            end
        end
    end

    assign bus.Swrequest        = w_swrequest;
    assign bus.busy             = (r_state != S_IDLE);
    assign bus.grant_id         = r_owner;
    assign bus.err_spurious_ack = r_err;

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge Sclk or posedge Sreset) begin
        if (Sreset) begin
            r_state    <= S_IDLE;
            r_owner    <= 3'd0;
            r_ptr      <= 3'd0;
            r_err      <= 1'b0;
`ifdef SBUS_WARB_TIMEOUT_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            if (bus.Swack && !w_swrequest) r_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick_idx;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Owner withdrawing its request before the ack aborts the grant.
                    if (!w_req[r_owner]) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else if (bus.Swack) begin
                        if (w_lock[r_owner]) begin
                            r_state    <= S_HOLD;
`ifdef SBUS_WARB_TIMEOUT_EN
                            r_hold_cnt <= '0;
`endif
                        end else begin
                            r_ptr   <= w_next_ptr;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_lock[r_owner]) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else if (w_req[r_owner]) begin
                        r_state <= S_GRANT;
                    end
`ifdef SBUS_WARB_TIMEOUT_EN
                    else if (r_hold_cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
                        r_ptr   <= w_next_ptr;
                        r_state <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/sbus_warbiter.md
# sbus_warbiter

Round-robin arbiter that shares the single S-bus write channel among NREQ write requesters, typically several S-bus write controllers. It forwards one owner's request, address and data to the bus and routes Swack back only to that owner. An optional lock lets an owner keep the channel across a multi-beat burst. It sits between the write controllers and the external S-bus write port.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 48, address width
- DW, 176, data width
- HOLD_TIMEOUT, 16, idle cycles allowed in HOLD before forced release (used only with the macro)

- Sclk  in  1  clock
- Sreset  in  1  reset Sreset, asynchronous, active-high; clock Sclk
- req_wrequest  in  NREQ  per-requester write request
- req_lock  in  NREQ  keep grant after ack (burst)
- req_waddr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed data, requester i at [i*DW +: DW]
- req_wack  out  NREQ  per-requester ack, one-hot or zero
- Swack  in  1  bus write ack
- Swrequest  out  1  bus write request
- Swaddr  out  AW  bus address
- Swdata  out  DW  bus data
- grant_id  out  3  current owner index; valid when busy=1
- busy  out  1  state is not IDLE
- err_spurious_ack  out  1  sticky; set when Swack arrives while Swrequest=0

## Operation
- States: IDLE, GRANT, HOLD. Registers: state, owner, ptr (next-priority index), err flag, and a timeout counter when the macro is defined.
- IDLE: if any req_wrequest bit is set, select the first set index searching ptr, ptr+1, ..., wrapping modulo NREQ. Then owner<=idx and go to GRANT. Otherwise stay in IDLE.
- GRANT: Swrequest = req_wrequest[owner]. Swaddr and Swdata show the owner's slice while Swrequest=1 and are 0 otherwise. req_wack[owner] = Swack & Swrequest.
  - Swack & Swrequest & !req_lock[owner]: release, ptr<=(owner+1)%NREQ, go to IDLE.
  - Swack & Swrequest & req_lock[owner]: go to HOLD; ptr unchanged.
  - Owner drops req_wrequest before ack: treat as abort, release, ptr<=(owner+1)%NREQ, go to IDLE.
- HOLD: Swrequest=0. If req_lock[owner]=0, release (ptr advances) and go to IDLE. Else if req_wrequest[owner]=1, go to GRANT with the same owner. Other requesters wait.
- When Swack=1 and Swrequest=0 in any state: set err_spurious_ack (cleared only by reset). No req_wack is raised and state is unaffected.
- Non-owners always see req_wack=0.

## Timing
- Reset values: state=IDLE, owner=0, ptr=0, err=0, counter=0. All outputs are 0.
- Request to bus latency: 1 cycle. A request sampled in IDLE at edge k produces Swrequest high during cycle k+1.
- Swack is combinational to req_wack in the same cycle. The release edge is the same edge that samples Swack.
- Re-arbitration after release costs 1 IDLE cycle. Back-to-back beats from different owners therefore take at least 2 cycles per grant.
- A locked re-request (HOLD→GRANT) also takes 1 cycle.
- Asynchronous reset in the middle of a transfer drops Swrequest immediately and returns to IDLE. Any pending ack is lost.
- Widths: ptr, owner and grant_id are 3 bits. Only indices below NREQ are valid, and wrap is performed explicitly at NREQ-1→0.

## Configuration
- SBUS_WARB_TIMEOUT_EN defined: a counter increments each cycle in HOLD while req_wrequest[owner]=0 and clears on entry to HOLD. When it reaches HOLD_TIMEOUT, the arbiter force-releases the grant (ptr advances) and goes to IDLE even if req_lock stays high.
- Macro undefined: no counter is built, and HOLD persists until the owner drops the lock or re-requests.

## Test plan
- Reset: Sreset pulse mid-GRANT (owner=2) → Swrequest=0, busy=0, grant_id=0 immediately. The first request afterwards starts the search from index 0.
- Round robin: NREQ=4, all four requesting, Swack one cycle after each Swrequest → grant order 0,1,2,3,0. Each req_wack pulse is one-hot to its owner.
- Mux: requester 1 with waddr=48'h0000_1234_5678 and data=176'hA5…A5 → Swaddr and Swdata match exactly while Swrequest=1, and are 0 in IDLE.
- Lock burst: requester 3 with req_lock=1 for 3 beats while requester 0 requests continuously → three consecutive grants go to 3. Requester 0 is granted one cycle after requester 3 drops the lock.
- Spurious ack: Swack=1 in IDLE → err_spurious_ack=1 and it stays set, all req_wack=0, state remains IDLE.
- Timeout (macro on, HOLD_TIMEOUT=16): owner holds the lock but does not re-request → release after 16 HOLD cycles, and the next requester is granted. With the macro off, HOLD persists beyond 100 cycles.
